// File: rtl/seq_bcd_calc_if.sv
// Start/done handshake bundle between the keypad capture logic and seq_bcd_calc.
// SEQ_BCD_CALC_REM_EN adds the rem_bcd remainder return path.
interface seq_bcd_calc_if #(
    parameter int DIGITS = 2
);
    localparam int BIN_W = 4 * DIGITS;
    localparam int RES_W = 8 * DIGITS;

    logic             start;
    logic [1:0]       op;
    logic [BIN_W-1:0] a_bcd;
    logic [BIN_W-1:0] b_bcd;
    logic             busy;
    logic             done;
    logic [RES_W-1:0] result_bcd;
    logic             neg;
    logic             err_digit;
    logic             err_div0;
`ifdef SEQ_BCD_CALC_REM_EN
    logic [BIN_W-1:0] rem_bcd;

    modport master (
        output start, op, a_bcd, b_bcd,
        input  busy, done, result_bcd, neg, err_digit, err_div0, rem_bcd
    );
    modport slave (
        input  start, op, a_bcd, b_bcd,
        output busy, done, result_bcd, neg, err_digit, err_div0, rem_bcd
    );
`else
    modport master (
        output start, op, a_bcd, b_bcd,
        input  busy, done, result_bcd, neg, err_digit, err_div0
    );
    modport slave (
        input  start, op, a_bcd, b_bcd,
        output busy, done, result_bcd, neg, err_digit, err_div0
    );
`endif
endinterface

// File: rtl/seq_bcd_calc.sv
// Iterative BCD add/sub/mul/div: BCD->binary load, shift-add / restoring divide, double-dabble back.
// Define SEQ_BCD_CALC_REM_EN to add a second conversion pass that returns the div remainder.
module seq_bcd_calc #(
    parameter int DIGITS = 2
) (
    input  logic          clk,
    input  logic          rst,
    seq_bcd_calc_if.slave bus
);
    localparam int BIN_W = 4 * DIGITS;
    localparam int RES_W = 8 * DIGITS;
    localparam int CNT_W = $clog2(RES_W) + 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LOAD, S_EXEC, S_CONV, S_FIN} state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [BIN_W-1:0]   r_a_bcd, r_b_bcd;
    logic [BIN_W-1:0]   r_acc_a, r_acc_b;
    logic [2*BIN_W-1:0] r_work;
    logic [RES_W-1:0]   r_bin, r_bcd;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign;
    logic               r_busy, r_done, r_neg, r_err_digit, r_err_div0;
    logic [RES_W-1:0]   r_result;
`ifdef SEQ_BCD_CALC_REM_EN
    logic               r_pass2;
    logic [RES_W-1:0]   r_q_bcd;
    logic [BIN_W-1:0]   r_rem;
`endif

    logic               w_bad_digit;
    logic [BIN_W-1:0]   w_a_next, w_b_next;
    logic [BIN_W:0]     w_mul_sum;
    logic [2*BIN_W-1:0] w_mul_next;
    logic [BIN_W:0]     w_div_rs;
    logic [BIN_W-1:0]   w_div_diff;
    logic               w_div_ge;
    logic [2*BIN_W-1:0] w_div_next;
    logic [RES_W-1:0]   w_add3, w_bcd_next;

    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        w_bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_a_bcd[4*i +: 4] > 4'd9 || r_b_bcd[4*i +: 4] > 4'd9) w_bad_digit = 1'b1;
        end
    end

    // acc*10 + next digit, MSD first; partial sums always fit BIN_W bits.
    assign w_a_next = (r_acc_a << 3) + (r_acc_a << 1) + BIN_W'(r_a_bcd[BIN_W-1 -: 4]);
    assign w_b_next = (r_acc_b << 3) + (r_acc_b << 1) + BIN_W'(r_b_bcd[BIN_W-1 -: 4]);

    // r_work = {partial product | remainder, multiplier | quotient}.
    assign w_mul_sum  = {1'b0, r_work[2*BIN_W-1:BIN_W]} + (r_work[0] ? {1'b0, r_acc_b} : '0);
    assign w_mul_next = {w_mul_sum, r_work[BIN_W-1:1]};
    assign w_div_rs   = r_work[2*BIN_W-1:BIN_W-1];
    assign w_div_diff = w_div_rs[BIN_W-1:0] - r_acc_b;
    assign w_div_ge   = (w_div_rs >= {1'b0, r_acc_b});
    assign w_div_next = {(w_div_ge ? w_div_diff : w_div_rs[BIN_W-1:0]), r_work[BIN_W-2:0], w_div_ge};

    always_comb begin
        w_add3 = r_bcd;
        for (int i = 0; i < 2 * DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_add3[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end
    assign w_bcd_next = (w_add3 << 1) | RES_W'(r_bin[RES_W-1]);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_a_bcd     <= '0;
            r_b_bcd     <= '0;
            r_acc_a     <= '0;
            r_acc_b     <= '0;
            r_work      <= '0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_sign      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_neg       <= 1'b0;
            r_err_digit <= 1'b0;
            r_err_div0  <= 1'b0;
            r_result    <= '0;
`ifdef SEQ_BCD_CALC_REM_EN
            r_pass2     <= 1'b0;
            r_q_bcd     <= '0;
            r_rem       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op        <= bus.op;
                        r_a_bcd     <= bus.a_bcd;
                        r_b_bcd     <= bus.b_bcd;
                        r_sign      <= 1'b0;
                        r_neg       <= 1'b0;
                        r_err_digit <= 1'b0;
                        r_err_div0  <= 1'b0;
`ifdef SEQ_BCD_CALC_REM_EN
                        r_pass2     <= 1'b0;
                        r_rem       <= '0;
`endif
                        r_busy      <= 1'b1;
                        r_state     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_bad_digit) begin
                        r_err_digit <= 1'b1;
                        r_result    <= '0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_FIN;
                    end else if (r_op == OP_DIV && r_b_bcd == '0) begin
                        r_err_div0 <= 1'b1;
                        r_result   <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_FIN;
                    end else begin
                        r_acc_a <= '0;
                        r_acc_b <= '0;
                        r_cnt   <= CNT_W'(DIGITS - 1);
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_acc_a <= w_a_next;
                    r_acc_b <= w_b_next;
                    r_a_bcd <= r_a_bcd << 4;
                    r_b_bcd <= r_b_bcd << 4;
                    if (r_cnt == '0) begin
                        r_work  <= {BIN_W'(0), w_a_next};
                        r_cnt   <= CNT_W'(BIN_W - 1);
                        r_state <= S_EXEC;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    r_bcd <= '0;
                    case (r_op)
                        OP_ADD: begin
                            r_bin   <= RES_W'(r_acc_a) + RES_W'(r_acc_b);
                            r_cnt   <= CNT_W'(RES_W - 1);
                            r_state <= S_CONV;
                        end
                        OP_SUB: begin
                            if (r_acc_a >= r_acc_b) begin
                                r_bin <= RES_W'(r_acc_a - r_acc_b);
                            end else begin
                                r_bin  <= RES_W'(r_acc_b - r_acc_a);
                                r_sign <= 1'b1;
                            end
                            r_cnt   <= CNT_W'(RES_W - 1);
                            r_state <= S_CONV;
                        end
                        default: begin
                            r_work <= (r_op == OP_MUL) ? w_mul_next : w_div_next;
                            if (r_cnt == '0) begin
                                r_bin   <= (r_op == OP_MUL) ? w_mul_next : RES_W'(w_div_next[BIN_W-1:0]);
                                r_cnt   <= CNT_W'(RES_W - 1);
                                r_state <= S_CONV;
                            end else begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end
                        end
                    endcase
                end
                S_CONV: begin
                    r_bcd <= w_bcd_next;
                    r_bin <= r_bin << 1;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
`ifdef SEQ_BCD_CALC_REM_EN
                    end else if (r_op == OP_DIV && !r_pass2) begin
                        // Park the quotient digits and re-run the converter on the remainder.
                        r_pass2 <= 1'b1;
                        r_q_bcd <= w_bcd_next;
                        r_bcd   <= '0;
                        r_bin   <= {r_work[2*BIN_W-1:BIN_W], BIN_W'(0)};
                        r_cnt   <= CNT_W'(BIN_W - 1);
                    end else begin
                        r_result <= r_pass2 ? r_q_bcd : w_bcd_next;
                        r_rem    <= r_pass2 ? w_bcd_next[BIN_W-1:0] : '0;
                        r_neg    <= r_sign;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_FIN;
                    end
`else
                    end else begin
                        r_result <= w_bcd_next;
                        r_neg    <= r_sign;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_FIN;
                    end
`endif
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.result_bcd = r_result;
    assign bus.neg        = r_neg;
    assign bus.err_digit  = r_err_digit;
    assign bus.err_div0   = r_err_div0;
`ifdef SEQ_BCD_CALC_REM_EN
    assign bus.rem_bcd    = r_rem;
`endif
endmodule

// File: tb/tb_seq_bcd_calc.sv
// Self-checking bench for seq_bcd_calc: directed plan plus random ops against an integer-arithmetic model.
// Honours SEQ_BCD_CALC_REM_EN when the design is built with it.
module tb_seq_bcd_calc;
    localparam int DIGITS = 2;
    localparam int BIN_W  = 4 * DIGITS;
    localparam int RES_W  = 8 * DIGITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_bcd_calc_if #(.DIGITS(DIGITS)) bus ();
    seq_bcd_calc #(.DIGITS(DIGITS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] rem;
        bit          neg;
        bit          ed;
        bit          ez;
        int          lat;
    } exp_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bcd_val(input logic [BIN_W-1:0] v, output bit bad);
        int x = 0;
        bad = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            int d;
            d = int'(v[4*i +: 4]);
            if (d > 9) bad = 1'b1;
            x = x * 10 + d;
        end
        return x;
    endfunction

    function automatic logic [31:0] to_bcd(input int x);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [1:0] op, input logic [BIN_W-1:0] a, input logic [BIN_W-1:0] b);
        exp_t e;
        bit ba, bb;
        int av, bv, v;
        av = bcd_val(a, ba);
        bv = bcd_val(b, bb);
        e.res = '0; e.rem = '0; e.neg = 1'b0; e.ed = 1'b0; e.ez = 1'b0; e.lat = 2;
        v = 0;
        if (ba || bb) begin
            e.ed = 1'b1;
        end else if (op == 2'd3 && bv == 0) begin
            e.ez = 1'b1;
        end else begin
            case (op)
                2'd0: v = av + bv;
                2'd1: begin
                    if (av >= bv) v = av - bv;
                    else begin v = bv - av; e.neg = 1'b1; end
                end
                2'd2: v = av * bv;
                default: begin v = av / bv; e.rem = to_bcd(av % bv); end
            endcase
            e.res = to_bcd(v);
            e.lat = (op < 2'd2) ? 1 + DIGITS + 1 + RES_W + 1 : 1 + DIGITS + BIN_W + RES_W + 1;
`ifdef SEQ_BCD_CALC_REM_EN
            if (op == 2'd3) e.lat += BIN_W;
`endif
        end
        return e;
    endfunction

    task automatic launch(input logic [1:0] op, input logic [BIN_W-1:0] a, input logic [BIN_W-1:0] b);
        bus.op    = op;
        bus.a_bcd = a;
        bus.b_bcd = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int k = 1;
        while (bus.done !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        lat = (bus.done === 1'b1) ? k : -1;
    endtask

    task automatic check_op(input string tag, input logic [1:0] op, input logic [BIN_W-1:0] a,
                            input logic [BIN_W-1:0] b, input int lat);
        exp_t e;
        e = model(op, a, b);
        check({tag, "_lat"}, 32'(lat), 32'(e.lat));
        check({tag, "_res"}, 32'(bus.result_bcd), e.res);
        check({tag, "_neg"}, 32'(bus.neg), 32'(e.neg));
        check({tag, "_errd"}, 32'(bus.err_digit), 32'(e.ed));
        check({tag, "_err0"}, 32'(bus.err_div0), 32'(e.ez));
`ifdef SEQ_BCD_CALC_REM_EN
        check({tag, "_rem"}, 32'(bus.rem_bcd), e.rem);
`endif
    endtask

    // Issues one op, checks it, then steps off the done cycle so the next start is accepted.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [BIN_W-1:0] a,
                          input logic [BIN_W-1:0] b);
        int lat;
        launch(op, a, b);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(lat);
        check_op(tag, op, a, b, lat);
        tick();
    endtask

    function automatic logic [BIN_W-1:0] rand_bcd();
        logic [BIN_W-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 15) == 0) r[3:0] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    initial begin
        int k;
        int nd;
        logic [1:0] rop;
        logic [BIN_W-1:0] ra, rb;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.op = '0;
        bus.a_bcd = '0;
        bus.b_bcd = '0;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_res", 32'(bus.result_bcd), 32'd0);
        check("rst_flags", 32'({bus.neg, bus.err_digit, bus.err_div0}), 32'd0);
        rst = 1'b0;
        tick();

        run_op("add", 2'b00, 8'h45, 8'h67);
        run_op("sub_neg", 2'b01, 8'h12, 8'h47);
        run_op("sub_pos", 2'b01, 8'h47, 8'h12);
        run_op("sub_zero", 2'b01, 8'h00, 8'h00);
        run_op("mul_max", 2'b10, 8'h99, 8'h99);
        run_op("div", 2'b11, 8'h87, 8'h04);
        run_op("err_digit", 2'b11, 8'h3A, 8'h00);
        run_op("err_div0", 2'b11, 8'h50, 8'h00);
        run_op("div_by_one", 2'b11, 8'h99, 8'h01);
        run_op("mul_zero", 2'b10, 8'h00, 8'h73);

        // Extra starts mid-operation (with changed operands) must be ignored.
        launch(2'b10, 8'h99, 8'h12);
        k = 1;
        while (bus.done !== 1'b1 && k < 200) begin
            bus.start = (k == 5 || k == 20);
            if (k == 5 || k == 20) begin
                bus.op = 2'b00;
                bus.a_bcd = 8'h01;
                bus.b_bcd = 8'h01;
            end
            if (k == 2) check("hs_busy_mid", 32'(bus.busy), 32'd1);
            tick();
            k++;
        end
        bus.start = 1'b0;
        check_op("hs_mul", 2'b10, 8'h99, 8'h12, (bus.done === 1'b1) ? k : -1);
        // A start raised during the done cycle is dropped as well.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("hs_fin_start_busy", 32'(bus.busy), 32'd0);
        nd = 0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1) nd++;
        end
        check("hs_extra_done", 32'(nd), 32'd0);

        // Reset in the middle of a multiply aborts it outright.
        run_op("pre_rst", 2'b00, 8'h33, 8'h44);
        launch(2'b10, 8'h99, 8'h99);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_res", 32'(bus.result_bcd), 32'd0);
        nd = 0;
        repeat (40) begin
            tick();
            if (bus.done === 1'b1) nd++;
        end
        check("abort_no_done", 32'(nd), 32'd0);
        run_op("post_rst_add", 2'b00, 8'h01, 8'h01);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = rand_bcd();
            rb = rand_bcd();
            if (rop == 2'b11 && $urandom_range(0, 5) == 0) rb = '0;
            run_op($sformatf("rnd%0d", i), rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_bcd_calc.md
Name: seq_bcd_calc

Overview:
- Multi-cycle BCD arithmetic unit that replaces the combinational switch-driven calculator datapath.
- Accepts two DIGITS-digit unsigned BCD operands and an op code (add, sub, mul, div), computes iteratively, and returns a BCD result with sign and error flags over a start/done handshake.
- Sits between the switch/keypad capture logic and the 7-segment display drivers; display decoding stays outside this block.

Parameters:
- DIGITS, 2, BCD digits per operand (valid range 1..4).
- BIN_W, 4*DIGITS, localparam: binary width of one operand.
- RES_W, 8*DIGITS, localparam: result width (2*DIGITS BCD digits).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  operation: 00 add, 01 sub, 10 mul, 11 div; captured with start.
- a_bcd  input  4*DIGITS  operand A, packed BCD, most significant digit at the top; captured with start.
- b_bcd  input  4*DIGITS  operand B, packed BCD; captured with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when result and flags are valid.
- result_bcd  output  RES_W  packed BCD result magnitude; held until next accepted start.
- neg  output  1  result is negative (sub only); held with result_bcd.
- err_digit  output  1  an operand nibble was above 9; held with result_bcd.
- err_div0  output  1  div with B equal to 0; held with result_bcd.

Behaviour:
- Interface: one clock and one reset. clk is the clock; rst is synchronous and active-high.
- Reset: state IDLE; busy, done, neg, err_digit, err_div0 all 0; result_bcd 0; internal registers cleared.
- Reset mid-operation aborts within the same edge. No done pulse is produced and the outputs read the reset values.
- FSM states: IDLE, CHECK, LOAD, EXEC, CONV, FIN.
- IDLE: on start=1, register op, a_bcd and b_bcd, clear all flags, go to CHECK.
  - The captured copies are the only ones used, so input changes after that edge have no effect.
- CHECK (1 cycle):
  - If any nibble of A or B is above 9: set err_digit, result 0, go to FIN.
  - Else if op=div and B=0: set err_div0, result 0, go to FIN.
  - Otherwise go to LOAD.
  - err_digit takes priority over err_div0.
- LOAD (DIGITS cycles): one digit per cycle, MSD first, acc = acc*10 + digit, for A and B in parallel. Produces binary a and b, each BIN_W bits.
- EXEC:
  - add: 1 cycle, a+b.
  - sub: 1 cycle. If a>=b, a-b with neg=0. Else b-a with neg=1.
  - mul: BIN_W cycles, shift-add; product is 2*BIN_W bits and never overflows.
  - div: BIN_W cycles, restoring; quotient = floor(a/b), remainder retained internally.
- CONV (RES_W cycles): sequential double-dabble, one bit per cycle.
  - Add-3 to every digit >=5, then shift in the binary MSB.
  - Result is zero-extended to RES_W bits before conversion.
- FIN (1 cycle): load result_bcd, assert done for this cycle only, drop busy, return to IDLE.
- Error paths skip LOAD, EXEC and CONV.
- Latency, from the start-accepted edge to the done cycle:
  - add/sub: 1+DIGITS+1+RES_W+1 cycles (21 for DIGITS=2).
  - mul/div: 1+DIGITS+BIN_W+RES_W+1 cycles (28 for DIGITS=2).
  - error: 2 cycles.
- A start while busy=1 is ignored and not queued. A start in the same cycle as done (FIN) is also ignored.
- A start asserted on the cycle after done is accepted.
- A zero result yields result_bcd all zeros with neg=0. A 0-0 sub has neg=0.

Optional Feature:
- Macro: SEQ_BCD_CALC_REM_EN.
- When defined:
  - Adds output rem_bcd, width 4*DIGITS, holding the div remainder in BCD.
  - The remainder is converted in a second CONV pass of BIN_W cycles after the quotient, so div latency grows by BIN_W cycles (36 for DIGITS=2).
  - rem_bcd resets to 0, is 0 for non-div ops and on errors, and is held with result_bcd.
- When undefined: the port is absent, no second pass runs, and div latency is as listed above.

Test Plan (DIGITS=2):
- Add: a=0x45, b=0x67, op=00 -> done at cycle 21, result_bcd=0x0112, neg=0, errors 0.
- Sub, negative: a=0x12, b=0x47, op=01 -> result_bcd=0x0035, neg=1. Then a=0x47, b=0x12 -> 0x0035, neg=0. Then a=b=0x00 -> 0x0000, neg=0.
- Mul and div:
  - a=0x99, b=0x99, op=10 -> 0x9801 at cycle 28.
  - a=0x87, b=0x04, op=11 -> 0x0021; with SEQ_BCD_CALC_REM_EN, rem_bcd=0x03 at cycle 36.
- Errors:
  - a=0x3A, b=0x00, op=11 -> done at cycle 2, err_digit=1, err_div0=0, result 0.
  - a=0x50, b=0x00, op=11 -> err_div0=1.
- Handshake: start again at cycles 5 and 20 of a mul -> both ignored, exactly one done. start on the cycle after done -> accepted, busy=1 next cycle.
- Reset mid-operation: rst=1 at cycle 10 of a mul -> next cycle busy=0, result_bcd=0, no done pulse. A following add of 0x01+0x01 -> 0x0002.
